// File: rtl/stat_reg_ctrl_if.sv
// Status-report link between the main-control status sources and the
// downstream reporting link. The collector sits on the slave side: it consumes
// live status, sample enable, flush requests and the downstream ready, and
// produces the held report snapshot.
//
// Handshake: a report is transferred on a rising clock edge where
// out_valid_stat_reg_ctrl and in_ready_stat_reg_ctrl are both 1. Once
// out_valid_stat_reg_ctrl is raised, it and out_status_stat_reg_ctrl and
// out_overrun_stat_reg_ctrl stay stable until that transfer. The ready signal
// may be driven freely and never depends on valid.
interface stat_reg_ctrl_if #(
   parameter int STAT_W = 5
);
   logic [STAT_W-1:0] in_status_stat_reg_ctrl;
   logic              in_valid_stat_reg_ctrl;
   logic              in_flush_stat_reg_ctrl;
   logic              in_ready_stat_reg_ctrl;
   logic [STAT_W-1:0] out_status_stat_reg_ctrl;
   logic              out_valid_stat_reg_ctrl;
   logic              out_overrun_stat_reg_ctrl;

   // Status sources and downstream link side.
   modport master (
      output in_status_stat_reg_ctrl,
      output in_valid_stat_reg_ctrl,
      output in_flush_stat_reg_ctrl,
      output in_ready_stat_reg_ctrl,
      input  out_status_stat_reg_ctrl,
      input  out_valid_stat_reg_ctrl,
      input  out_overrun_stat_reg_ctrl
   );

   // Collector side.
   modport slave (
      input  in_status_stat_reg_ctrl,
      input  in_valid_stat_reg_ctrl,
      input  in_flush_stat_reg_ctrl,
      input  in_ready_stat_reg_ctrl,
      output out_status_stat_reg_ctrl,
      output out_valid_stat_reg_ctrl,
      output out_overrun_stat_reg_ctrl
   );
endinterface

// File: rtl/stat_reg_ctrl.sv
// Status collector for the main-control block.
// Samples live status flags, latches the STICKY_MASK flags until a report
// carrying them is accepted, and produces reports on a flush request, a
// periodic tick or (optionally) a change of the effective status. A report is
// a snapshot held under valid/ready until the downstream link accepts it;
// triggers that arrive while a report is pending are dropped and flagged as
// overrun in the following report.
module stat_reg_ctrl #(
   parameter int                STAT_W        = 5,
   parameter logic [STAT_W-1:0] STICKY_MASK   = STAT_W'(5'b01000),
   parameter int                AUTO_PERIOD   = 0,
   parameter bit                CHANGE_REPORT = 1'b0
) (
   input  logic           in_clk_stat_reg_ctrl,
   input  logic           in_rst_n_stat_reg_ctrl,
   stat_reg_ctrl_if.slave bus,
   output logic [0:0]     dbg_state
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   localparam int CW = $clog2(AUTO_PERIOD) + 1;

   logic [0:0]        state_q;
   logic [STAT_W-1:0] live_q;
   logic [STAT_W-1:0] sticky_q;
   logic [STAT_W-1:0] last_q;
   logic              overrun_pend_q;
   logic [STAT_W-1:0] out_status_q;
   logic              out_valid_q;
   logic              out_overrun_q;

   logic [STAT_W-1:0] eff;
   logic [STAT_W-1:0] new_events;
   logic [STAT_W-1:0] sticky_kept;
   logic              tick;
   logic              chg;
   logic              trig;
   logic              accept;

   // Effective status comes from registers only, so a sample taken in the
   // trigger cycle is not part of that cycle's snapshot.
   assign eff        = (live_q & ~STICKY_MASK) | sticky_q;
   assign new_events = bus.in_valid_stat_reg_ctrl ?
                       (bus.in_status_stat_reg_ctrl & STICKY_MASK) : '0;
   // Only sticky bits that were actually reported are released on accept;
   // bits latched after the snapshot survive.
   assign sticky_kept = accept ? (sticky_q & ~out_status_q) : sticky_q;

   assign chg    = CHANGE_REPORT && (eff != last_q);
   assign trig   = bus.in_flush_stat_reg_ctrl | tick | chg;
   assign accept = out_valid_q & bus.in_ready_stat_reg_ctrl;

   generate
      if (AUTO_PERIOD > 0) begin : g_tick
         localparam logic [CW-1:0] CNT_LAST = CW'(AUTO_PERIOD - 1);
         logic [CW-1:0] cnt_q;

         // Free-running period counter; wraps after the last count.
         always_ff @(posedge in_clk_stat_reg_ctrl) begin
            if (!in_rst_n_stat_reg_ctrl) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end

         assign tick = (cnt_q == CNT_LAST);
      end else begin : g_no_tick
         assign tick = 1'b0;
      end
   endgenerate

   // Live sample, sticky latch and last-accepted status tracking.
   always_ff @(posedge in_clk_stat_reg_ctrl) begin
      if (!in_rst_n_stat_reg_ctrl) begin
         live_q   <= '0;
         sticky_q <= '0;
         last_q   <= '0;
      end else begin
         if (bus.in_valid_stat_reg_ctrl) begin
            live_q <= bus.in_status_stat_reg_ctrl;
         end
         sticky_q <= sticky_kept | new_events;
         if (accept) begin
            last_q <= out_status_q;
         end
      end
   end

   // Overrun bookkeeping: the pending flag moves into the snapshot when a
   // report is taken, and any trigger seen while a report is held (including
   // in its accept cycle) is dropped and re-arms it for the next report.
   always_ff @(posedge in_clk_stat_reg_ctrl) begin
      if (!in_rst_n_stat_reg_ctrl) begin
         overrun_pend_q <= 1'b0;
      end else if (trig) begin
         overrun_pend_q <= (state_q == ST_HOLD);
      end
   end

   // Report FSM: IDLE takes a snapshot on a trigger, HOLD keeps it stable
   // until accept. No back-to-back report out of the accept cycle.
   always_ff @(posedge in_clk_stat_reg_ctrl) begin
      if (!in_rst_n_stat_reg_ctrl) begin
         state_q       <= ST_IDLE;
         out_status_q  <= '0;
         out_valid_q   <= 1'b0;
         out_overrun_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (trig) begin
                  out_status_q  <= eff;
                  out_overrun_q <= overrun_pend_q;
                  out_valid_q   <= 1'b1;
                  state_q       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (accept) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.out_status_stat_reg_ctrl  = out_status_q;
   assign bus.out_valid_stat_reg_ctrl   = out_valid_q;
   assign bus.out_overrun_stat_reg_ctrl = out_overrun_q;
   assign dbg_state                     = state_q;

endmodule
